// File: rtl/pifo_pop_drain_pkg.sv
// rtl/pifo_pop_drain_pkg.sv - shared types and constants for the PIFO pop-side drain
// Contents:
//   PIFO_PTW / PIFO_MTW / PIFO_DW  default payload, metadata and total data widths
//   pifo_dw()                      data width helper (metadata + payload)
//   pifo_data_t                    default-width tree data word
//   drain_state_e                  pop issue FSM states
//   PIFO_EMPTY_VALUE               all-ones data word the tree returns when it has nothing
package pifo_pop_drain_pkg;

    localparam int PIFO_PTW = 16;
    localparam int PIFO_MTW = 0;

    function automatic int pifo_dw(input int mtw, input int ptw);
        return mtw + ptw;
    endfunction

    localparam int PIFO_DW = pifo_dw(PIFO_MTW, PIFO_PTW);

    typedef logic [PIFO_DW-1:0] pifo_data_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } drain_state_e;

    localparam pifo_data_t PIFO_EMPTY_VALUE = '1;

endpackage

// File: rtl/pifo_pop_drain_if.sv
// rtl/pifo_pop_drain_if.sv - tree pop handshake plus egress stream bundle
// Signals:
//   push_seen  tree accepted a push this cycle (strobe)
//   pop        pop request pulse to the tree
//   pop_data   tree data, valid a fixed latency after pop
//   tvalid / tdata / tready  egress stream toward the scheduler
// Modports: master = drain side, slave = tree + egress side.
interface pifo_pop_drain_if
    import pifo_pop_drain_pkg::*;
#(
    parameter int DW = PIFO_DW
);
    logic          push_seen;
    logic          pop;
    logic [DW-1:0] pop_data;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tready;

    modport master (
        input  push_seen,
        output pop,
        input  pop_data,
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        output push_seen,
        input  pop,
        output pop_data,
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/pifo_pop_drain_fifo.sv
// rtl/pifo_pop_drain_fifo.sv - first-word fall-through egress buffer with occupancy count
// Ports:
//   i_clk, i_arst_n   clock, async active-low reset (pointers and count)
//   wr_en, wr_data    write port; a write to a full buffer is only taken alongside a read
//   rd_en             consume the head entry (ignored when empty)
//   rd_data           head entry, zero while empty
//   empty, count      buffer status
module pifo_pop_drain_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    assign do_rd = rd_en && (cnt != '0);
    assign do_wr = wr_en && ((cnt != FULL) || do_rd);

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = (cnt == '0) ? '0 : mem[rd_ptr];
    assign empty   = (cnt == '0);
    assign count   = cnt;

endmodule

// File: rtl/pifo_pop_drain.sv
// rtl/pifo_pop_drain.sv - pop-side client of the SRAM PIFO tree feeding an egress stream
// Ports:
//   i_clk, i_arst_n   clock, async active-low reset
//   bus (master)      push_seen / pop / pop_data toward the tree, tvalid / tdata / tready egress
//   o_occupancy       elements held in the tree (excludes in-flight and buffered)
//   o_empty           o_occupancy == 0
//   o_ovf             sticky: push seen while occupancy saturated at all-ones
//   o_pop_cnt, o_stall_cnt  pops issued / cycles blocked on credit, only with PIFO_DRAIN_STATS_EN
module pifo_pop_drain
    import pifo_pop_drain_pkg::*;
#(
    parameter int PTW        = PIFO_PTW,
    parameter int MTW        = PIFO_MTW,
    parameter int POP_LAT    = 2,
    parameter int POP_GAP    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int OCW        = 20
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    pifo_pop_drain_if.master   bus,
    output logic [OCW-1:0]     o_occupancy,
    output logic               o_empty,
    output logic               o_ovf
`ifdef PIFO_DRAIN_STATS_EN
    ,
    output logic [31:0]        o_pop_cnt,
    output logic [31:0]        o_stall_cnt
`endif
);
    localparam int DW = pifo_dw(MTW, PTW);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

    drain_state_e       state;
    logic [GW-1:0]      gap_cnt;
    logic               pop_r;
    logic [POP_LAT-1:0] pipe;
    logic [OCW-1:0]     occ;
    logic [OCW-1:0]     occ_next;
    logic               ovf;
    logic               ovf_set;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      inflight;
    logic [CW:0]        used;
    logic               credit;
    logic               allowed;
    logic               fifo_empty;
    logic               tap;

    // Pipe stage POP_LAT-1 lines up with the cycle the tree presents the popped word.
    assign tap = pipe[POP_LAT-1];

    always_comb begin
        occ_next = occ;
        ovf_set  = 1'b0;
        case ({bus.push_seen, pop_r})
            2'b10: begin
                if (&occ) ovf_set = 1'b1;
                else      occ_next = occ + 1'b1;
            end
            2'b01:   occ_next = occ - 1'b1;
            default: ;
        endcase
    end

    // The pulse currently on o_pop counts as in flight so a decision never
    // over-commits the buffer; reads only ever free space, so this is safe.
    always_comb begin
        inflight = {{(CW-1){1'b0}}, pop_r};
        for (int i = 0; i < POP_LAT; i++) begin
            inflight = inflight + {{(CW-1){1'b0}}, pipe[i]};
        end
        used = {1'b0, fifo_count} + {1'b0, inflight};
    end

    assign credit = (used < DEPTH_V);
    // Decide on next cycle's occupancy so a push seen now can pop next cycle.
    assign allowed = (occ_next != '0) && credit;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state   <= IDLE;
            gap_cnt <= '0;
            pop_r   <= 1'b0;
            pipe    <= '0;
            occ     <= '0;
            ovf     <= 1'b0;
        end else begin
            occ   <= occ_next;
            pipe  <= (pipe << 1) | POP_LAT'(pop_r);
            pop_r <= 1'b0;
            if (ovf_set) ovf <= 1'b1;
            case (state)
                IDLE: begin
                    if (allowed) begin
                        state <= ISSUE;
                        pop_r <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (POP_GAP > 1) begin
                        state   <= HOLD;
                        gap_cnt <= GW'(POP_GAP - 2);
                    end else if (allowed) begin
                        state <= ISSUE;
                        pop_r <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (allowed) begin
                        state <= ISSUE;
                        pop_r <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pifo_pop_drain_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_arst_n (i_arst_n),
        .wr_en    (tap),
        .wr_data  (bus.pop_data),
        .rd_en    (bus.tvalid && bus.tready),
        .rd_data  (bus.tdata),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign bus.pop     = pop_r;
    assign bus.tvalid  = !fifo_empty;
    assign o_occupancy = occ;
    assign o_empty     = (occ == '0);
    assign o_ovf       = ovf;

`ifdef PIFO_DRAIN_STATS_EN
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_pop_cnt   <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (pop_r) o_pop_cnt <= o_pop_cnt + 1'b1;
            if ((occ != '0) && !credit) o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pifo_pop_drain.sv
// tb/tb_pifo_pop_drain.sv - self-checking bench for pifo_pop_drain
module tb_pifo_pop_drain;
    import pifo_pop_drain_pkg::*;

    localparam int DW      = 16;
    localparam int POP_LAT = 2;
    localparam int POP_GAP = 2;
    localparam int DEPTH   = 4;
    localparam int OCW     = 4;
    localparam int OCC_MAX = (1 << OCW) - 1;

    typedef struct {
        int            t;
        logic [DW-1:0] d;
    } pend_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [OCW-1:0] o_occupancy;
    logic           o_empty;
    logic           o_ovf;
`ifdef PIFO_DRAIN_STATS_EN
    logic [31:0]    pop_cnt;
    logic [31:0]    stall_cnt;
`endif

    pifo_pop_drain_if #(.DW(DW)) bus ();

    pifo_pop_drain #(
        .PTW(DW), .MTW(0), .POP_LAT(POP_LAT), .POP_GAP(POP_GAP),
        .FIFO_DEPTH(DEPTH), .OCW(OCW)
    ) dut (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .bus         (bus),
        .o_occupancy (o_occupancy),
        .o_empty     (o_empty),
        .o_ovf       (o_ovf)
`ifdef PIFO_DRAIN_STATS_EN
        ,
        .o_pop_cnt   (pop_cnt),
        .o_stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: tree contents, pop order, egress log, occupancy counter.
    logic [DW-1:0] tree_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] beat_q[$];
    int            beat_cyc[$];
    int            pop_cyc[$];
    pend_t         pend[$];
    int m_occ, m_ovf, m_popped, m_beats, m_stall, m_underflow, min_gap, max_out, last_pop;

    int            s_cyc, exp_occ;
    logic          s_pop, s_push, s_tvalid, s_empty, s_ovf;
    logic [DW-1:0] s_tdata;
    logic [OCW-1:0] s_occ;

    task automatic clear_model();
        tree_q.delete(); exp_q.delete(); beat_q.delete(); beat_cyc.delete();
        pop_cyc.delete(); pend.delete();
        m_occ = 0; m_ovf = 0; m_popped = 0; m_beats = 0; m_stall = 0; m_underflow = 0;
        min_gap = 1000; max_out = 0; last_pop = -1;
    endtask

    // One clock: sample at the falling edge, act as the tree, update the model.
    task automatic tick();
        int out;
        logic [DW-1:0] d;
        pend_t pe;
        @(negedge clk);
        s_cyc = cyc; s_pop = bus.pop; s_push = bus.push_seen; s_tvalid = bus.tvalid;
        s_tdata = bus.tdata; s_occ = o_occupancy; s_empty = o_empty; s_ovf = o_ovf;
        exp_occ = m_occ;
        if (s_push) tree_q.push_back(DW'($urandom));
        if (s_pop) begin
            m_popped++;
            pop_cyc.push_back(s_cyc);
            if (last_pop >= 0 && (s_cyc - last_pop) < min_gap) min_gap = s_cyc - last_pop;
            last_pop = s_cyc;
            if (tree_q.size() == 0) m_underflow++;
            else begin
                d = tree_q.pop_front();
                exp_q.push_back(d);
                pe.t = s_cyc + POP_LAT; pe.d = d;
                pend.push_back(pe);
            end
        end
        if (pend.size() > 0 && pend[0].t == s_cyc) begin
            bus.pop_data = pend[0].d;
            void'(pend.pop_front());
        end else begin
            bus.pop_data = PIFO_EMPTY_VALUE;
        end
        out = m_popped - m_beats;
        if (out > max_out) max_out = out;
        if (exp_occ != 0 && out >= DEPTH) m_stall++;
        if (s_tvalid && bus.tready) begin
            beat_q.push_back(s_tdata); beat_cyc.push_back(s_cyc); m_beats++;
        end
        if (s_push && !s_pop) begin
            if (m_occ == OCC_MAX) m_ovf = 1; else m_occ++;
        end else if (!s_push && s_pop && m_occ > 0) begin
            m_occ--;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.push_seen = 1'b0; bus.tready = 1'b0; bus.pop_data = '0;
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.pop !== 1'b0) begin errors++; $display("FAIL reset_pop got %b want 0", bus.pop); end
        checks++; if (bus.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", bus.tvalid); end
        checks++; if (bus.tdata !== '0) begin errors++; $display("FAIL reset_tdata got %h want 0", bus.tdata); end
        checks++; if (o_occupancy !== '0) begin errors++; $display("FAIL reset_occ got %0d want 0", o_occupancy); end
        checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", o_empty); end
        checks++; if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
    endtask

    task automatic test_basic();
        int p, bad;
        do_reset();
        bus.tready = 1'b1;
        p = cyc;
        repeat (3) begin bus.push_seen = 1'b1; tick(); end
        bus.push_seen = 1'b0;
        repeat (20) tick();
        checks++;
        if (pop_cyc.size() != 3) begin errors++; $display("FAIL basic_pops got %0d want 3", pop_cyc.size()); end
        else begin
            checks++; if (pop_cyc[0] != p + 1) begin errors++; $display("FAIL basic_first_pop got %0d want %0d", pop_cyc[0], p + 1); end
            checks++; if (pop_cyc[1] - pop_cyc[0] != POP_GAP || pop_cyc[2] - pop_cyc[1] != POP_GAP) begin
                errors++; $display("FAIL basic_spacing got %0d,%0d want %0d", pop_cyc[1] - pop_cyc[0], pop_cyc[2] - pop_cyc[1], POP_GAP); end
        end
        checks++;
        if (beat_q.size() != 3 || exp_q.size() != 3) begin errors++; $display("FAIL basic_beats got %0d want 3", beat_q.size()); end
        else begin
            bad = 0;
            for (int i = 0; i < 3; i++) if (beat_q[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL basic_order got %0d wrong beats want 0", bad); end
            checks++; if (beat_cyc[0] != p + POP_LAT + 2) begin errors++; $display("FAIL basic_latency got %0d want %0d", beat_cyc[0], p + POP_LAT + 2); end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        bus.tready = 1'b0;
        repeat (10) begin bus.push_seen = 1'b1; tick(); end
        bus.push_seen = 1'b0;
        repeat (30) tick();
        checks++; if (pop_cyc.size() != DEPTH) begin errors++; $display("FAIL bp_pops got %0d want %0d", pop_cyc.size(), DEPTH); end
        checks++; if (s_occ !== 4'd6) begin errors++; $display("FAIL bp_occ got %0d want 6", s_occ); end
        checks++; if (s_tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid got %b want 1", s_tvalid); end
        bus.tready = 1'b1;
        repeat (60) tick();
        checks++; if (pop_cyc.size() != 10 || beat_q.size() != 10) begin
            errors++; $display("FAIL bp_drain got pops %0d beats %0d want 10", pop_cyc.size(), beat_q.size()); end
        else begin
            bad = 0;
            for (int i = 0; i < 10; i++) if (beat_q[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL bp_order got %0d wrong beats want 0", bad); end
        end
        checks++; if (s_occ !== '0 || s_empty !== 1'b1) begin errors++; $display("FAIL bp_final got occ %0d empty %b want 0 1", s_occ, s_empty); end
        checks++; if (min_gap < POP_GAP || max_out > DEPTH) begin errors++; $display("FAIL bp_limits got gap %0d out %0d want >=%0d <=%0d", min_gap, max_out, POP_GAP, DEPTH); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.tready = 1'b1;
        bus.push_seen = 1'b1; tick();
        tick();
        checks++; if (s_pop !== 1'b1 || s_occ !== 4'd1) begin errors++; $display("FAIL simul_issue got pop %b occ %0d want 1 1", s_pop, s_occ); end
        bus.push_seen = 1'b0; tick();
        checks++; if (s_occ !== 4'd1) begin errors++; $display("FAIL simul_occ got %0d want 1", s_occ); end
        repeat (20) tick();
        checks++; if (s_occ !== '0 || m_underflow != 0 || beat_q.size() != 2) begin
            errors++; $display("FAIL simul_drain got occ %0d underflow %0d beats %0d want 0 0 2", s_occ, m_underflow, beat_q.size()); end
    endtask

    task automatic test_saturate();
        int n;
        do_reset();
        bus.tready = 1'b0;
        n = 0;
        bus.push_seen = 1'b1;
        while (m_occ < OCC_MAX && n < 100) begin tick(); n++; end
        bus.push_seen = 1'b0;
        tick();
        checks++; if (s_occ !== 4'(OCC_MAX) || s_ovf !== 1'b0) begin
            errors++; $display("FAIL sat_full got occ %0d ovf %b want %0d 0", s_occ, s_ovf, OCC_MAX); end
        bus.push_seen = 1'b1; tick();
        bus.push_seen = 1'b0; tick();
        checks++; if (s_occ !== 4'(OCC_MAX) || s_ovf !== 1'b1) begin
            errors++; $display("FAIL sat_ovf got occ %0d ovf %b want %0d 1", s_occ, s_ovf, OCC_MAX); end
    endtask

    task automatic test_reset_inflight();
        int n;
        do_reset();
        bus.tready = 1'b0;
        repeat (4) begin bus.push_seen = 1'b1; tick(); end
        bus.push_seen = 1'b0;
        n = 0;
        while (!(bus.pop === 1'b1 && m_popped >= 2) && n < 50) begin tick(); n++; end
        checks++; if (n >= 50 || bus.tvalid !== 1'b1) begin
            errors++; $display("FAIL rst_setup got tvalid %b waited %0d want 1 <50", bus.tvalid, n); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.pop !== 1'b0 || bus.tvalid !== 1'b0 || o_occupancy !== '0) begin
            errors++; $display("FAIL rst_async got pop %b tvalid %b occ %0d want 0 0 0", bus.pop, bus.tvalid, o_occupancy); end
        clear_model();
        @(negedge clk);
        bus.pop_data = DW'($urandom);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.tready = 1'b1;
        repeat (10) tick();
        checks++; if (beat_q.size() != 0 || pop_cyc.size() != 0 || s_occ !== '0) begin
            errors++; $display("FAIL rst_late got beats %0d pops %0d occ %0d want 0 0 0", beat_q.size(), pop_cyc.size(), s_occ); end
    endtask

    task automatic test_random();
        int bad;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.push_seen = (m_occ < 12) && ($urandom_range(0, 2) == 0);
            bus.tready = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (s_occ !== 4'(exp_occ)) begin errors++; $display("FAIL rand_occ cycle %0d got %0d want %0d", s_cyc, s_occ, exp_occ); end
        end
        bus.push_seen = 1'b0; bus.tready = 1'b1;
        repeat (40) tick();
        checks++; if (m_underflow != 0 || min_gap < POP_GAP || max_out > DEPTH) begin
            errors++; $display("FAIL rand_limits got underflow %0d gap %0d out %0d", m_underflow, min_gap, max_out); end
        checks++; if (beat_q.size() != exp_q.size() || tree_q.size() != 0) begin
            errors++; $display("FAIL rand_count got beats %0d want %0d left %0d", beat_q.size(), exp_q.size(), tree_q.size()); end
        bad = 0;
        for (int i = 0; i < beat_q.size() && i < exp_q.size(); i++) if (beat_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_order got %0d wrong beats want 0", bad); end
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL rand_ovf got %b want 0", s_ovf); end
`ifdef PIFO_DRAIN_STATS_EN
        checks++; if (pop_cnt !== 32'(m_popped)) begin errors++; $display("FAIL stats_pop got %0d want %0d", pop_cnt, m_popped); end
        checks++; if (stall_cnt !== 32'(m_stall)) begin errors++; $display("FAIL stats_stall got %0d want %0d", stall_cnt, m_stall); end
`endif
    endtask

    initial begin
        bus.push_seen = 1'b0;
        bus.tready = 1'b0;
        bus.pop_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_simultaneous();
        test_saturate();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
